// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, 2-flop input synchronizer,
// mid-bit sampling, false-start rejection and break recovery.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_LAST =
    CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [CW-1:0] BIT_LAST =
    CW'(CLKS_PER_BIT - 1);

  localparam logic [CW-1:0] BAUD_ONE = CW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          rx_meta;
  logic          rx_sync;
  logic [CW-1:0] baud;
  logic [CW-1:0] baud_nxt;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_nxt;
  logic [7:0]    shift;
  logic [7:0]    shift_nxt;
  logic [7:0]    data_nxt;
  logic          valid_nxt;
  logic          ferr_nxt;

  // Two-flop synchronizer; idles at the line's mark level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // State, counters and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
    end else begin
      state   <= state_nxt;
      baud    <= baud_nxt;
      bit_cnt <= bit_nxt;
      shift   <= shift_nxt;
    end
  end

  // Next-state logic; outputs decided at the stop sample.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    data_nxt  = data_out;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_sync) begin
          state_nxt = START;
          baud_nxt  = '0;
        end
      end

      START: begin
        if (baud == HALF_LAST) begin
          baud_nxt = '0;
          bit_nxt  = 3'd0;
          if (rx_sync) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
          end
        end else begin
          baud_nxt = baud + BAUD_ONE;
        end
      end

      DATA: begin
        if (baud == BIT_LAST) begin
          shift_nxt[bit_cnt] = rx_sync;
          baud_nxt = '0;
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_cnt + 3'd1;
          end
        end else begin
          baud_nxt = baud + BAUD_ONE;
        end
      end

      STOP: begin
        if (baud == BIT_LAST) begin
          baud_nxt = '0;
          if (rx_sync) begin
            data_nxt  = shift;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end else begin
          baud_nxt = baud + BAUD_ONE;
        end
      end

      WAIT_IDLE: begin
        if (rx_sync) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        baud_nxt  = '0;
        bit_nxt   = 3'd0;
      end
    endcase
  end

  // Registered outputs; busy tracks the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      data_out  <= data_nxt;
      rx_valid  <= valid_nxt;
      frame_err <= ferr_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx
// at 16 and 8 clocks per bit against a byte-level model.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx16;
  logic       rx8;
  logic [7:0] d16;
  logic [7:0] d8;
  logic       v16;
  logic       v8;
  logic       fe16;
  logic       fe8;
  logic       b16;
  logic       b8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] got16_q[$];
  int         cyc16_q[$];
  logic [7:0] got8_q[$];
  int         fe16_n = 0;
  int         fe8_n = 0;
  int         both_n = 0;

  uart_rx #(.CLKS_PER_BIT(16)) dut16 (
    .clk(clk), .rst(rst), .rx(rx16),
    .data_out(d16), .rx_valid(v16),
    .frame_err(fe16), .busy(b16)
  );

  uart_rx #(.CLKS_PER_BIT(8)) dut8 (
    .clk(clk), .rst(rst), .rx(rx8),
    .data_out(d8), .rx_valid(v8),
    .frame_err(fe8), .busy(b8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder, sampled on the inactive edge.
  always @(negedge clk) begin
    if (v16) begin
      got16_q.push_back(d16);
      cyc16_q.push_back(cyc);
    end
    if (v8) got8_q.push_back(d8);
    if (fe16) fe16_n <= fe16_n + 1;
    if (fe8) fe8_n <= fe8_n + 1;
    if ((v16 && fe16) || (v8 && fe8))
      both_n <= both_n + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx8 = v;
    else rx16 = v;
  endtask

  // One frame; data bits are wrong for jit cycles at each end.
  task automatic send(input bit sel, input logic [7:0] b,
                      input logic stopv, input int stop_cyc,
                      input int jit);
    int c;
    c = sel ? 8 : 16;
    set_rx(sel, 1'b0);
    wait_cyc(c);
    for (int i = 0; i < 8; i++) begin
      if (jit > 0) begin
        set_rx(sel, ~b[i]);
        wait_cyc(jit);
      end
      set_rx(sel, b[i]);
      wait_cyc(c - 2 * jit);
      if (jit > 0) begin
        set_rx(sel, ~b[i]);
        wait_cyc(jit);
      end
    end
    set_rx(sel, stopv);
    wait_cyc(stop_cyc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx16 = 1'b1;
    rx8 = 1'b1;
    wait_cyc(3);
    checks++;
    if (d16 !== 8'h00 || v16 !== 1'b0 ||
        fe16 !== 1'b0 || b16 !== 1'b0) begin
      errors++;
      $display("FAIL reset16 got d=%h v=%b fe=%b busy=%b want 00 0 0 0",
               d16, v16, fe16, b16);
    end
    checks++;
    if (d8 !== 8'h00 || v8 !== 1'b0 ||
        fe8 !== 1'b0 || b8 !== 1'b0) begin
      errors++;
      $display("FAIL reset8 got d=%h v=%b fe=%b busy=%b want 00 0 0 0",
               d8, v8, fe8, b8);
    end
    rst = 1'b0;
    wait_cyc(5);
    checks++;
    if (b16 !== 1'b0 || b8 !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b/%b want 0/0",
               b16, b8);
    end
  endtask

  task automatic test_frame_a5();
    int n0;
    int f0;
    n0 = got16_q.size();
    f0 = fe16_n;
    send(1'b0, 8'hA5, 1'b1, 16, 4);
    wait_cyc(4);
    checks++;
    if (got16_q.size() - n0 != 1) begin
      errors++;
      $display("FAIL a5_count got %0d want 1", got16_q.size() - n0);
    end else begin
      checks++;
      if (got16_q[n0] !== 8'hA5) begin
        errors++;
        $display("FAIL a5_data got %h want a5", got16_q[n0]);
      end
    end
    checks++;
    if (fe16_n != f0 || b16 !== 1'b0) begin
      errors++;
      $display("FAIL a5_fe_busy got fe=%0d busy=%b want 0 0",
               fe16_n - f0, b16);
    end
  endtask

  task automatic test_false_start();
    int n0;
    int f0;
    logic seen;
    logic [7:0] prev;
    n0 = got16_q.size();
    f0 = fe16_n;
    prev = d16;
    seen = 1'b0;
    rx16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_cyc(1);
      seen = seen | b16;
    end
    rx16 = 1'b1;
    for (int i = 0; i < 24; i++) begin
      wait_cyc(1);
      seen = seen | b16;
    end
    checks++;
    if (seen !== 1'b1 || b16 !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy got seen=%b end=%b want 1 0",
               seen, b16);
    end
    checks++;
    if (got16_q.size() != n0 || fe16_n != f0 || d16 !== prev) begin
      errors++;
      $display("FAIL glitch_quiet got v=%0d fe=%0d d=%h want 0 0 %h",
               got16_q.size() - n0, fe16_n - f0, d16, prev);
    end
  endtask

  task automatic test_frame_err();
    int n0;
    int f0;
    logic [7:0] prev;
    n0 = got16_q.size();
    f0 = fe16_n;
    prev = d16;
    send(1'b0, 8'h3C, 1'b0, 16 * 40, 4);
    checks++;
    if (fe16_n - f0 != 1 || got16_q.size() != n0) begin
      errors++;
      $display("FAIL ferr_pulse got fe=%0d v=%0d want 1 0",
               fe16_n - f0, got16_q.size() - n0);
    end
    checks++;
    if (b16 !== 1'b1 || d16 !== prev) begin
      errors++;
      $display("FAIL ferr_hold got busy=%b d=%h want 1 %h",
               b16, d16, prev);
    end
    rx16 = 1'b1;
    wait_cyc(6);
    checks++;
    if (b16 !== 1'b0) begin
      errors++;
      $display("FAIL ferr_recover got busy=%b want 0", b16);
    end
    send(1'b0, 8'h81, 1'b1, 16, 4);
    wait_cyc(4);
    checks++;
    if (got16_q.size() - n0 != 1 || d16 !== 8'h81 ||
        fe16_n - f0 != 1) begin
      errors++;
      $display("FAIL ferr_next got v=%0d d=%h fe=%0d want 1 81 1",
               got16_q.size() - n0, d16, fe16_n - f0);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    logic [7:0] exp_b[3];
    exp_b[0] = 8'h00;
    exp_b[1] = 8'hFF;
    exp_b[2] = 8'h55;
    n0 = got16_q.size();
    for (int i = 0; i < 3; i++)
      send(1'b0, exp_b[i], 1'b1, 16, 3);
    wait_cyc(6);
    checks++;
    if (got16_q.size() - n0 != 3) begin
      errors++;
      $display("FAIL b2b_count got %0d want 3", got16_q.size() - n0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got16_q[n0 + i] !== exp_b[i]) begin
          errors++;
          $display("FAIL b2b_data%0d got %h want %h",
                   i, got16_q[n0 + i], exp_b[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (cyc16_q[n0 + i] - cyc16_q[n0 + i - 1] != 160) begin
          errors++;
          $display("FAIL b2b_gap%0d got %0d want 160", i,
                   cyc16_q[n0 + i] - cyc16_q[n0 + i - 1]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int n0;
    int f0;
    n0 = got16_q.size();
    f0 = fe16_n;
    rx16 = 1'b0;
    wait_cyc(16);
    for (int i = 0; i < 4; i++) begin
      rx16 = i[0];
      wait_cyc(16);
    end
    rx16 = 1'b0;
    wait_cyc(8);
    rst = 1'b1;
    wait_cyc(3);
    checks++;
    if (b16 !== 1'b0 || v16 !== 1'b0 || d16 !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid got busy=%b v=%b d=%h want 0 0 00",
               b16, v16, d16);
    end
    rx16 = 1'b1;
    rst = 1'b0;
    wait_cyc(200);
    checks++;
    if (got16_q.size() != n0 || fe16_n != f0) begin
      errors++;
      $display("FAIL rst_abort got v=%0d fe=%0d want 0 0",
               got16_q.size() - n0, fe16_n - f0);
    end
    send(1'b0, 8'hC3, 1'b1, 16, 4);
    wait_cyc(4);
    checks++;
    if (got16_q.size() - n0 != 1 || d16 !== 8'hC3) begin
      errors++;
      $display("FAIL rst_next got v=%0d d=%h want 1 c3",
               got16_q.size() - n0, d16);
    end
  endtask

  task automatic test_clk8();
    int n0;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    n0 = got8_q.size();
    exp_q.push_back(8'h96);
    send(1'b1, 8'h96, 1'b1, 8, 2);
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send(1'b1, b, 1'b1, 8, 2);
    end
    wait_cyc(6);
    checks++;
    if (got8_q.size() - n0 != exp_q.size() || fe8_n != 0) begin
      errors++;
      $display("FAIL clk8_count got %0d fe=%0d want %0d 0",
               got8_q.size() - n0, fe8_n, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got8_q[n0 + i] !== exp_q[i]) begin
          errors++;
          $display("FAIL clk8_data%0d got %h want %h",
                   i, got8_q[n0 + i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int n0;
    int f0;
    int exp_fe;
    int gap;
    logic bad;
    logic [7:0] b;
    logic [7:0] last;
    logic [7:0] exp_q[$];
    n0 = got16_q.size();
    f0 = fe16_n;
    exp_fe = 0;
    last = d16;
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      gap = $urandom_range(0, 20);
      send(1'b0, b, ~bad, 16, $urandom_range(0, 4));
      if (bad) begin
        exp_fe++;
        rx16 = 1'b1;
        wait_cyc(16 + gap);
      end else begin
        exp_q.push_back(b);
        last = b;
        wait_cyc(gap);
      end
    end
    wait_cyc(40);
    checks++;
    if (got16_q.size() - n0 != exp_q.size() ||
        fe16_n - f0 != exp_fe) begin
      errors++;
      $display("FAIL rand_count got v=%0d fe=%0d want %0d %0d",
               got16_q.size() - n0, fe16_n - f0,
               exp_q.size(), exp_fe);
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got16_q[n0 + i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_data%0d got %h want %h",
                   i, got16_q[n0 + i], exp_q[i]);
        end
      end
    end
    checks++;
    if (d16 !== last || b16 !== 1'b0) begin
      errors++;
      $display("FAIL rand_final got d=%h busy=%b want %h 0",
               d16, b16, last);
    end
    checks++;
    if (both_n != 0) begin
      errors++;
      $display("FAIL excl_pulses got %0d overlaps want 0", both_n);
    end
  endtask

  initial begin
    rst = 1'b1;
    rx16 = 1'b1;
    rx8 = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_frame_a5();
    test_false_start();
    test_frame_err();
    test_back_to_back();
    test_reset_midframe();
    test_clk8();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
